// File: rtl/alu_mdu_seq_pkg.sv
// Shared op codes, state encoding and operand-select constants for the EX-stage ALU/MDU.
package alu_mdu_seq_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_SLL    = 5'd5;
    localparam logic [4:0] ALU_SR     = 5'd6;
    localparam logic [4:0] ALU_SLT    = 5'd7;
    localparam logic [4:0] ALU_PASS   = 5'd8;
    localparam logic [4:0] MDU_MUL    = 5'd9;
    localparam logic [4:0] MDU_MULH   = 5'd10;
    localparam logic [4:0] MDU_MULHSU = 5'd11;
    localparam logic [4:0] MDU_DIV    = 5'd12;
    localparam logic [4:0] MDU_REM    = 5'd13;

    localparam logic OPA_RS1 = 1'b0;
    localparam logic OPA_PC  = 1'b1;
    localparam logic OPB_RS2 = 1'b0;
    localparam logic OPB_IMM = 1'b1;

    localparam logic ENG_MUL = 1'b0;
    localparam logic ENG_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mdu_seq_mdu_iter_engine.sv
// Shared radix-2 engine: shift-add multiply or restoring divide on unsigned magnitudes.
module mdu_iter_engine
    import alu_mdu_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic            i_start,
    input  logic            i_mode,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic             r_busy;
    logic             r_done;
    logic             r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_b;

    logic [XLEN:0]    w_mul_sum;
    logic             w_div_ge;
    logic [XLEN-1:0]  w_div_shift;
    logic [XLEN-1:0]  w_div_sub;
    logic             w_last;

    // Multiply: {hi,lo} shifts right one bit per step, adding B when the multiplier LSB is set.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    // Divide: the partial remainder can transiently need XLEN+1 bits, so compare at that width.
    assign w_div_ge    = {r_hi, r_lo[XLEN-1]} >= {1'b0, r_b};
    assign w_div_shift = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
    assign w_div_sub   = w_div_shift - r_b;
    assign w_last      = (r_cnt == CNT_W'(XLEN - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
                r_mode <= i_mode;
            end else if (r_busy) begin
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_start) begin
            r_hi <= '0;
            r_lo <= i_a;
            r_b  <= i_b;
        end else if (r_busy) begin
            if (r_mode == ENG_MUL) begin
                r_hi <= w_mul_sum[XLEN:1];
                r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end else begin
                r_hi <= w_div_ge ? w_div_sub : w_div_shift;
                r_lo <= {r_lo[XLEN-2:0], w_div_ge};
            end
        end
    end

    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/alu_mdu_seq.sv
// EX-stage integer unit: single-cycle RV32I ALU plus iterative RV32M multiply/divide
// behind a valid/ready handshake with flush.
module alu_mdu_seq
    import alu_mdu_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OP_W  = 5,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic            is_signed,
    input  logic            a_sel,
    input  logic            b_sel,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int SH_W = $clog2(XLEN);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_result;
    logic [OP_W-1:0]   r_op_lat;
    logic              r_neg_prod;
    logic              r_neg_a;

    logic [XLEN-1:0]   w_a;
    logic [XLEN-1:0]   w_b;
    logic [SH_W-1:0]   w_shamt;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_iter;
    logic              w_start;
    logic [XLEN-1:0]   w_alu;
    logic              w_eng_done;
    logic [XLEN-1:0]   w_eng_hi;
    logic [XLEN-1:0]   w_eng_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_iter_res;

    assign w_a     = (a_sel == OPA_PC)  ? pc  : rs1;
    assign w_b     = (b_sel == OPB_IMM) ? imm : rs2;
    assign w_shamt = w_b[SH_W-1:0];

    assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready) && !flush && !rst;
    assign w_accept   = in_valid && w_in_ready;

    assign w_is_mul = (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU);
    assign w_is_div = (op == MDU_DIV) || (op == MDU_REM);

    // MULHSU always treats A as signed; plain MUL needs no sign handling for its low half.
    assign w_a_sgn = (is_signed && ((op == MDU_MULH) || w_is_div)) || (op == MDU_MULHSU);
    assign w_b_sgn = is_signed && ((op == MDU_MULH) || w_is_div);
    assign w_a_neg = w_a_sgn && w_a[XLEN-1];
    assign w_b_neg = w_b_sgn && w_b[XLEN-1];
    assign w_a_mag = w_a_neg ? (-w_a) : w_a;
    assign w_b_mag = w_b_neg ? (-w_b) : w_b;

    assign w_div_zero = (w_b == '0);
    assign w_div_ovf  = is_signed && (w_a == {1'b1, {(XLEN-1){1'b0}}}) && (w_b == {XLEN{1'b1}});
    assign w_iter     = w_is_mul || (w_is_div && !w_div_zero && !w_div_ovf);
    assign w_start    = w_accept && w_iter;

    // Single-cycle results, including the divide special cases.
    always_comb begin
        w_alu = '0;
        case (op)
            ALU_ADD:  w_alu = w_a + w_b;
            ALU_SUB:  w_alu = w_a - w_b;
            ALU_AND:  w_alu = w_a & w_b;
            ALU_OR:   w_alu = w_a | w_b;
            ALU_XOR:  w_alu = w_a ^ w_b;
            ALU_SLL:  w_alu = w_a << w_shamt;
            ALU_SR:   w_alu = is_signed ? $unsigned($signed(w_a) >>> w_shamt) : (w_a >> w_shamt);
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}},
                               is_signed ? ($signed(w_a) < $signed(w_b)) : (w_a < w_b)};
            ALU_PASS: w_alu = w_b;
            MDU_DIV:  w_alu = w_div_zero ? {XLEN{1'b1}} : w_a;
            MDU_REM:  w_alu = w_div_zero ? w_a : '0;
            default:  w_alu = '0;
        endcase
    end

    mdu_iter_engine #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_engine (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (flush),
        .i_start (w_start),
        .i_mode  (w_is_div ? ENG_DIV : ENG_MUL),
        .i_a     (w_a_mag),
        .i_b     (w_b_mag),
        .o_done  (w_eng_done),
        .o_hi    (w_eng_hi),
        .o_lo    (w_eng_lo)
    );

    always_ff @(posedge clk) begin
        if (w_start) begin
            r_op_lat   <= op;
            r_neg_prod <= w_a_neg ^ w_b_neg;
            r_neg_a    <= w_a_neg;
        end
    end

    assign w_prod = r_neg_prod ? (-{w_eng_hi, w_eng_lo}) : {w_eng_hi, w_eng_lo};

    always_comb begin
        w_iter_res = '0;
        case (r_op_lat)
            MDU_MUL:    w_iter_res = w_prod[XLEN-1:0];
            MDU_MULH,
            MDU_MULHSU: w_iter_res = w_prod[2*XLEN-1:XLEN];
            MDU_DIV:    w_iter_res = r_neg_prod ? (-w_eng_lo) : w_eng_lo;
            default:    w_iter_res = r_neg_a ? (-w_eng_hi) : w_eng_hi;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        w_state_nxt = w_is_mul ? S_MUL : S_DIV;
                    end
                end
                S_MUL, S_DIV: begin
                    if (w_eng_done) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A result handed off this cycle may be replaced by a new base-op result in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && !w_iter) begin
                r_result    <= w_alu;
                r_out_valid <= 1'b1;
            end else if ((r_state != S_IDLE) && w_eng_done) begin
                r_result    <= w_iter_res;
                r_out_valid <= 1'b1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq: base ops, MUL/DIV latency and values, backpressure, flush, reset.
module tb_alu_mdu_seq;
    import alu_mdu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic        is_signed;
    logic        a_sel;
    logic        b_sel;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int          checks   = 0;
    int          failures = 0;
    int          seen;
    logic [31:0] last_exp;

    always #5 clk = ~clk;

    alu_mdu_seq #(
        .XLEN (32),
        .OP_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .is_signed (is_signed),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .rs1       (rs1),
        .rs2       (rs2),
        .pc        (pc),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Unselected operand sources carry junk so a wrong mux shows up in the result.
    task automatic drive(input logic [4:0] o, input logic s, input logic as, input logic bs,
                         input logic [31:0] a, input logic [31:0] b);
        op        = o;
        is_signed = s;
        a_sel     = as;
        b_sel     = bs;
        rs1       = as ? 32'hDEADBEEF : a;
        pc        = as ? a : 32'hDEADBEEF;
        rs2       = bs ? 32'hCAFEF00D : b;
        imm       = bs ? b : 32'hCAFEF00D;
        in_valid  = 1'b1;
    endtask

    task automatic do_op(input string tag, input logic [4:0] o, input logic s,
                         input logic as, input logic bs, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        drive(o, s, as, bs, a, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check(tag, result, exp);
        last_exp = exp;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; is_signed = 1'b0; a_sel = 1'b0; b_sel = 1'b0;
        rs1 = '0; rs2 = '0; pc = '0; imm = '0; last_exp = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        do_op("add",      ALU_ADD,  1'b0, 1'b0, 1'b0, 32'd7, 32'd5, 32'd12, 0);
        do_op("add_pcimm", ALU_ADD, 1'b0, 1'b1, 1'b1, 32'h100, 32'd4, 32'h104, 0);
        do_op("sub",      ALU_SUB,  1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'hFFFFFFFE, 0);
        do_op("and",      ALU_AND,  1'b0, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0);
        do_op("or",       ALU_OR,   1'b0, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0);
        do_op("xor",      ALU_XOR,  1'b0, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0);
        do_op("sll",      ALU_SLL,  1'b0, 1'b0, 1'b1, 32'd1, 32'h3F, 32'h80000000, 0);
        do_op("sra",      ALU_SR,   1'b1, 1'b0, 1'b0, 32'h80000000, 32'd4, 32'hF8000000, 0);
        do_op("srl",      ALU_SR,   1'b0, 1'b0, 1'b0, 32'h80000000, 32'd4, 32'h08000000, 0);
        do_op("slt",      ALU_SLT,  1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd1, 0);
        do_op("sltu",     ALU_SLT,  1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 0);
        do_op("sltu_lt",  ALU_SLT,  1'b0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd1, 0);
        do_op("pass",     ALU_PASS, 1'b0, 1'b0, 1'b1, 32'd9, 32'h12345678, 32'h12345678, 0);
        do_op("undef_op", 5'd31,    1'b0, 1'b0, 1'b0, 32'd7, 32'd5, 32'd0, 0);

        do_op("mul",      MDU_MUL,    1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33);
        do_op("mulh",     MDU_MULH,   1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
        do_op("mulhu",    MDU_MULH,   1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, 32'h00000001, 33);
        do_op("mulhsu",   MDU_MULHSU, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);

        do_op("div_by0",  MDU_DIV, 1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 32'hFFFFFFFF, 0);
        do_op("rem_by0",  MDU_REM, 1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 32'd7, 0);
        do_op("div_ovf",  MDU_DIV, 1'b1, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        do_op("rem_ovf",  MDU_REM, 1'b1, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0);
        do_op("div_neg",  MDU_DIV, 1'b1, 1'b0, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        do_op("rem_neg",  MDU_REM, 1'b1, 1'b0, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        do_op("divu",     MDU_DIV, 1'b0, 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 33);
        do_op("remu",     MDU_REM, 1'b0, 1'b0, 1'b0, 32'd100, 32'd7, 32'd2, 33);

        // Backpressure: hold the ADD result while a second request waits.
        out_ready = 1'b0;
        drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
        @(posedge clk); #1;
        drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 32'd10, 32'd20);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_hold", result, 32'd3);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_b2b_valid", 32'(out_valid), 32'd1);
        check("bp_b2b_result", result, 32'd30);
        @(posedge clk); #1;
        check("bp_drain_valid", 32'(out_valid), 32'd0);
        last_exp = 32'd30;

        // Flush during iteration 10 of a divide, with an ADD waiting.
        drive(MDU_DIV, 1'b0, 1'b0, 1'b0, 32'd100, 32'd7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3);
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_result_kept", result, last_exp);
        flush = 1'b0;
        #1;
        check("post_flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_flush_add_valid", 32'(out_valid), 32'd1);
        check("post_flush_add", result, 32'd5);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_no_div_valid", 32'(seen), 32'd0);

        // Reset in the middle of a multiply.
        drive(MDU_MUL, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrst_no_mul_valid", 32'(seen), 32'd0);
        do_op("add_after_rst", ALU_ADD, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised, registered integer execute unit for the NPC EX stage.
- Covers the RV32I ALU operations plus the RV32M multiply and divide operations.
- Base ops complete in one cycle. MUL and DIV families run on a shared iterative radix-2 engine.
- Valid/ready handshake on input and output; a flush input aborts in-flight work on redirect.

Parameters:
- XLEN, 32, datapath width; must be ≥ 8 and a power of 2.
- OP_W, 5, width of the op field.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  abort in-flight op and drop any pending result
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- op  in  OP_W  operation code
- is_signed  in  1  signedness for SR, SLT, MULH, DIV, REM
- a_sel  in  1  operand A source: 0 = rs1, 1 = pc
- b_sel  in  1  operand B source: 0 = rs2, 1 = imm
- rs1, rs2, pc, imm  in  XLEN each  operand sources
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result

Behaviour:
- Accept = in_valid && in_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush.
- Operands are selected by a_sel/b_sel and latched on accept.
- States:
  - IDLE: accept base op → write result, out_valid=1 next cycle. Accept MUL-family → MUL. Accept DIV/REM → DIV, except special cases.
  - MUL: XLEN iterations of shift-add on magnitudes, then sign-correct.
  - DIV: XLEN iterations of restoring division on magnitudes, then sign-correct.
  - After the last iteration → result written, out_valid=1, state IDLE.
- Iterative latency: out_valid rises exactly XLEN+1 cycles after the accept edge. Counter runs 0..XLEN-1.
- Base ops:
  - ADD, SUB, AND, OR, XOR, PASS (= B).
  - SLL/SR: shift amount B[$clog2(XLEN)-1:0]. SR is arithmetic if is_signed, else logical.
  - SLT: {0…, A<B}, signed or unsigned per is_signed. Upper bits are always 0.
- MUL family (2·XLEN product):
  - MUL returns the low XLEN bits.
  - MULH returns the high XLEN bits: signed×signed if is_signed, else unsigned×unsigned.
  - MULHSU returns the high XLEN bits of signed A × unsigned B.
- DIV/REM signed or unsigned per is_signed; quotient rounds toward zero and the remainder takes the dividend's sign.
- DIV/REM special cases complete in one cycle, like base ops:
  - B == 0: DIV = all-ones; REM = A.
  - Signed, A == most-negative and B == -1: DIV = A; REM = 0.
- Output hold: result and out_valid stay stable while out_valid && !out_ready. out_valid drops on the cycle after the handshake unless a new base op is accepted in that same cycle (back-to-back allowed).
- flush (wins over all else except rst):
  - State → IDLE, counter cleared, out_valid → 0 next cycle. result keeps its value.
  - A request presented in the flush cycle is not accepted.
- Reset values: out_valid=0, result=0, state=IDLE, counter=0, in_ready=0 during rst.
- Reset mid-op abandons the op with no residual out_valid.
- op codes outside the defined set: treated as a base op with result 0.

Decomposition:
- Op codes (ALU_ADD … ALU_PASS, MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM), state encodings, and OPA/OPB select constants go in the shared defines.vh.
- Sub-module: mdu_iter_engine. It holds the shared shift register, accumulator and counter for shift-add and restoring division, and takes start/mode/magnitudes and returns done/hi/lo.
- Top level owns the handshake, the FSM, the base ALU and sign correction.

Test Plan:
- XLEN=32, ADD rs1=7 rs2=5 a_sel=0 b_sel=0 → result=12, out_valid one cycle after accept.
- SLT is_signed=1 A=0xFFFFFFFF B=1 → 1. SLTU same operands → 0. SLTU A=1 B=2 → 1.
- MUL A=0xFFFFFFFF B=2:
  - low → 0xFFFFFFFE
  - MULH signed → 0xFFFFFFFF
  - MULHU → 0x00000001
  - MULHSU → 0xFFFFFFFF
  - each with out_valid exactly 33 cycles after accept.
- Signed DIV/REM:
  - DIV 7/0 → 0xFFFFFFFF and REM → 7, in 1 cycle.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
  - DIV −7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF.
- Backpressure: hold out_ready=0 for 5 cycles after ADD → result stable, in_ready=0, a queued request is not accepted. Release → the request is accepted in the handshake cycle.
- Assert flush on iteration 10 of DIV → no out_valid ever for that op; a new ADD is accepted the cycle after flush. Repeat with rst mid-MUL → outputs return to reset values.
